// File: rtl/heap_arbiter.sv
// Round-robin arbiter that serialises alloc/free requests from NUM_REQ requesters
// onto a single heap allocator and returns a one-cycle ack per served request.
module heap_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_alloc,
  input  logic [NUM_REQ-1:0]             req_free,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_free_addr,
  output logic [NUM_REQ-1:0]             ack,
  output logic [ADDR_BITS-1:0]           ack_addr,
  output logic                           busy,
  output logic                           heap_alloc,
  output logic                           heap_free,
  output logic [ADDR_BITS-1:0]           heap_free_addr,
  input  logic [ADDR_BITS-1:0]           heap_alloc_addr,
  input  logic                           heap_finished
);

  // Handshake: a requester holds req_alloc/req_free (level) until it sees ack[i]
  // for one cycle and must drop the served bit by the edge that ends that cycle.
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t               state;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     gnt;
  logic [PTR_W-1:0]     sel;
  logic [PTR_W-1:0]     cand;
  logic                 any_pend;
  logic                 op_alloc;
  logic [NUM_REQ-1:0]   pend;
  logic [ADDR_BITS-1:0] slice_addr [NUM_REQ];

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
    if (v == PTR_W'(NUM_REQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  assign pend = req_alloc | req_free;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice_addr[i] = req_free_addr[i*ADDR_BITS +: ADDR_BITS];
  end

  // First pending requester at or after ptr, searching cyclically.
  always_comb begin
    sel      = '0;
    any_pend = 1'b0;
    cand     = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_pend && pend[cand]) begin
        any_pend = 1'b1;
        sel      = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // Strobes drop in the finished cycle so the heap sees exactly one operation.
  assign busy       = (state != IDLE);
  assign heap_alloc = (state == ISSUE) &  op_alloc & ~heap_finished;
  assign heap_free  = (state == ISSUE) & ~op_alloc & ~heap_finished;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      gnt            <= '0;
      op_alloc       <= 1'b0;
      ack            <= '0;
      ack_addr       <= '0;
      heap_free_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pend) begin
            gnt            <= sel;
            op_alloc       <= req_alloc[sel];
            heap_free_addr <= slice_addr[sel];
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (heap_finished) begin
            if (op_alloc) ack_addr <= heap_alloc_addr;
            ptr   <= wrap_inc(gnt);
            ack   <= NUM_REQ'(1) << gnt;
            state <= ACK;
          end
        end
        ACK: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
